aes_key_expander: RTL and testbench
===================================

# aes_key_expander

AES-128 key-schedule stage that sits directly upstream of the decipher datapath. It accepts a 128-bit cipher key and computes all eleven round keys sequentially. SubWord is performed one byte at a time through a dedicated external forward S-Box ROM. The finished keys are stored and served by round index, so the decipher block can fetch `round_key` for any round (10 down to 0) after `ready` is high.

## Interface
- `ROM_WAIT`, default 1: ROM access time in clk cycles, range 1..7.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `init` in 1: single-cycle start pulse; sampled only in IDLE.
- `key` in 128: cipher key; sampled on the accepting edge.
- `round` in 4: round index to read.
- `round_key` out 128: stored key for `round`; combinational mux.
- `ready` out 1: high when all 11 keys are valid and the block is idle.
- `rom_addr` out 8: S-Box ROM address, registered.
- `rom_data` in 8: S-Box ROM data, meaning S[rom_addr].
- `rom_ce_n` out 1: ROM chip enable, active low, registered.
- `rom_oe_n` out 1: ROM output enable, active low, registered.

## Operation
- **Key store:** 11 x 128-bit registers, k[0..10]. Word order is big-endian: w0 = bits [127:96].
- **FSM states:**
  - IDLE
  - LOOKUP: byte counter b = 0..3, wait counter 0..ROM_WAIT.
  - COMBINE
- **IDLE:**
  - On `init`=1: k[0] <= `key`; working words <= `key`; round counter r <= 1; `ready` <= 0.
  - On the same edge, drive the first ROM address and assert both strobes low.
  - Go to LOOKUP.
- **LOOKUP:**
  - temp = RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  - Byte b of temp, MSB first, is looked up through the ROM.
- **COMBINE:**
  - t = SubWord(temp) ^ {Rcon[r], 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - k[r] <= {w0', w1', w2', w3'}.
  - If r < 10: r <= r+1, drive the next round's first address, return to LOOKUP.
  - If r == 10: `ready` <= 1, strobes high, go to IDLE.
- **Rcon[1..10]:** 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **`round_key`:** equals k[`round`] for `round` 0..10; equals 128'h0 for `round` 11..15.
  - Readable at any time, but contents are valid only while `ready`=1.
- **`init` while busy:** ignored. No restart, no effect on the sequence.
- **`init` while `ready`=1:** starts a fresh expansion. `ready` drops on the accepting edge.
- **Reset, asserted at any time including mid-expansion:** all key registers and working words are cleared, FSM goes to IDLE, and the outputs take their reset values. No partial results survive.
- **Outputs at reset:**
  - `ready`=0, `rom_addr`=8'h00, `rom_ce_n`=1, `rom_oe_n`=1.
  - `round_key`=0 for every `round`.

## Timing
- **Per byte:** 1+ROM_WAIT edges.
  - The address is registered at edge t.
  - `rom_data` is sampled at edge t+1+ROM_WAIT.
  - The next byte's address is registered on that same sample edge.
- **Strobes:** `rom_ce_n` and `rom_oe_n` stay low continuously from the `init` edge until the round-10 COMBINE edge.
- **`rom_addr`:** changes only on byte-sample edges and COMBINE edges.
- **Per round:** 4*(1+ROM_WAIT) LOOKUP edges plus 1 COMBINE edge.
- **Key write timing:** with E0 = the `init` accepting edge, k[r] is written at E0 + r*(4*(1+ROM_WAIT)+1).
- **Latency to `ready`:**
  - ROM_WAIT=1: `ready` rises at E0+90.
  - ROM_WAIT=2: `ready` rises at E0+130.
- **`ready` pulse width:** `ready` stays high until the next accepted `init` or a reset.
- **`round_key` read path:** zero-latency combinational mux, so `round` may change every cycle.

## Test plan
- **FIPS-197 key, ROM_WAIT=1:** `key`=2b7e151628aed2a6abf7158809cf4f3c.
  - `ready` rises exactly 90 edges after the `init` edge.
  - `round`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `round`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `round`=0 returns the key.
- **All-zero key, ROM_WAIT=2:**
  - `round`=1 gives 62636363626363636263636362636363.
  - `round`=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
  - `ready` rises at E0+130.
  - First `rom_addr`=00, and each address holds for 3 cycles.
- **ROM protocol check, FIPS key, round 1:**
  - `rom_addr` sequence is cf, 4f, 3c, 09.
  - `rom_ce_n`/`rom_oe_n` are low from E0 through the round-10 COMBINE edge and high otherwise.
- **`init` during expansion:**
  - Pulse `init` with a different key at E0+40.
  - The result is unchanged: FIPS vectors as above, `ready` still at E0+90.
- **Reset mid-operation:**
  - Assert `reset_n`=0 at E0+50.
  - `ready`=0, strobes high, `rom_addr`=00, and `round_key`=0 for rounds 0..10.
  - A fresh `init` after release produces the correct FIPS keys.
- **Out-of-range index and re-init:**
  - `round`=11..15 returns 0.
  - A second `init` while `ready`=1 drops `ready` on the accepting edge and reproduces the all-zero-key vectors.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 round keys, one S-Box byte per ROM access.
// Latency 10*(4*(1+ROM_WAIT)+1) clk from init to ready; no backpressure, init is ignored while busy.
`timescale 1ns/1ps
module aes_key_expander #(
   parameter int ROM_WAIT = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         init,
   input  logic [127:0] key,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready,
   output logic [7:0]   rom_addr,
   input  logic [7:0]   rom_data,
   output logic         rom_ce_n,
   output logic         rom_oe_n
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOOKUP  = 2'd1;
   localparam logic [1:0] S_COMBINE = 2'd2;

   localparam logic [2:0] WAIT_LAST = 3'(ROM_WAIT);

   logic [1:0]   state;
   logic [127:0] k_store [0:10];
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sub_word;
   logic [3:0]   r_cnt;
   logic [1:0]   byte_cnt;
   logic [2:0]   wait_cnt;

   logic [31:0]  t_word;
   logic [31:0]  nw0, nw1, nw2, nw3;

   // Byte b (MSB first) of RotWord(w).
   function automatic logic [7:0] temp_byte(input logic [31:0] w, input logic [1:0] b);
      logic [31:0] rot;
      rot = {w[23:0], w[31:24]};
      case (b)
         2'd0:    return rot[31:24];
         2'd1:    return rot[23:16];
         2'd2:    return rot[15:8];
         default: return rot[7:0];
      endcase
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      t_word = sub_word ^ {rcon(r_cnt), 24'h0};
      nw0    = w0 ^ t_word;
      nw1    = w1 ^ nw0;
      nw2    = w2 ^ nw1;
      nw3    = w3 ^ nw2;
   end

   always_comb begin
      round_key = '0;
      if (round <= 4'd10) begin
         round_key = k_store[round];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         w0       <= '0;
         w1       <= '0;
         w2       <= '0;
         w3       <= '0;
         sub_word <= '0;
         r_cnt    <= '0;
         byte_cnt <= '0;
         wait_cnt <= '0;
         ready    <= 1'b0;
         rom_addr <= 8'h00;
         rom_ce_n <= 1'b1;
         rom_oe_n <= 1'b1;
         for (int i = 0; i < 11; i++) begin
            k_store[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (init) begin
                  k_store[0]           <= key;
                  {w0, w1, w2, w3}     <= key;
                  r_cnt                <= 4'd1;
                  byte_cnt             <= 2'd0;
                  wait_cnt             <= 3'd0;
                  ready                <= 1'b0;
                  rom_addr             <= temp_byte(key[31:0], 2'd0);
                  rom_ce_n             <= 1'b0;
                  rom_oe_n             <= 1'b0;
                  state                <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               // Data is taken once the address has been held for ROM_WAIT further edges.
               if (wait_cnt == WAIT_LAST) begin
                  sub_word <= {sub_word[23:0], rom_data};
                  wait_cnt <= 3'd0;
                  if (byte_cnt == 2'd3) begin
                     state <= S_COMBINE;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                     rom_addr <= temp_byte(w3, byte_cnt + 2'd1);
                  end
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            S_COMBINE: begin
               k_store[r_cnt]   <= {nw0, nw1, nw2, nw3};
               {w0, w1, w2, w3} <= {nw0, nw1, nw2, nw3};
               byte_cnt         <= 2'd0;
               wait_cnt         <= 3'd0;
               if (r_cnt == 4'd10) begin
                  ready    <= 1'b1;
                  rom_ce_n <= 1'b1;
                  rom_oe_n <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  r_cnt    <= r_cnt + 4'd1;
                  rom_addr <= temp_byte(nw3, 2'd0);
                  state    <= S_LOOKUP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: two instances (ROM_WAIT 1 and 2), each with a latency-accurate S-Box ROM model,
// and a scoreboard of expected round keys filled when init is driven and drained when ready rises.
`timescale 1ns/1ps
module tb_aes_key_expander;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n;
   logic         init_s   [2];
   logic [127:0] key_s    [2];
   logic [3:0]   round_s  [2];
   logic [127:0] rk_s     [2];
   logic         ready_s  [2];
   logic [7:0]   addr_s   [2];
   logic [7:0]   data_s   [2];
   logic         ce_s     [2];
   logic         oe_s     [2];

   int vectors     = 0;
   int miscompares = 0;
   logic [127:0] sb_q[$];

   logic [2047:0] sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] a);
      return sbox_flat[2047 - 8*int'(a) -: 8];
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
      logic [7:0]  rc;
      logic [31:0] w0, w1, w2, w3, t;
      rc = 8'h01;
      for (int n = 1; n < r; n++) rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      {w0, w1, w2, w3} = k;
      t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Address expected on rom_addr just after edge E0+i.
   function automatic logic [7:0] exp_addr(input logic [127:0] k, input int rw, input int i);
      int p, rl, r, b;
      logic [127:0] kk;
      logic [31:0]  rot;
      p  = 1 + rw;
      rl = 4*p + 1;
      r  = i / rl + 1;
      b  = (i % rl) / p;
      if (b > 3) b = 3;
      kk = k;
      for (int n = 1; n < r; n++) kk = next_key(kk, n);
      rot = {kk[23:0], kk[31:24]};
      return rot[31 - 8*b -: 8];
   endfunction

   aes_key_expander #(.ROM_WAIT(1)) dut_w1 (
      .clk(clk), .reset_n(reset_n), .init(init_s[0]), .key(key_s[0]), .round(round_s[0]),
      .round_key(rk_s[0]), .ready(ready_s[0]), .rom_addr(addr_s[0]), .rom_data(data_s[0]),
      .rom_ce_n(ce_s[0]), .rom_oe_n(oe_s[0]));

   aes_key_expander #(.ROM_WAIT(2)) dut_w2 (
      .clk(clk), .reset_n(reset_n), .init(init_s[1]), .key(key_s[1]), .round(round_s[1]),
      .round_key(rk_s[1]), .ready(ready_s[1]), .rom_addr(addr_s[1]), .rom_data(data_s[1]),
      .rom_ce_n(ce_s[1]), .rom_oe_n(oe_s[1]));

   // ROM returns S[addr] only once the address has been stable for ROM_WAIT edges and both strobes are low.
   for (genvar g = 0; g < 2; g++) begin : g_rom
      logic [7:0] last_addr = 8'h00;
      int         age       = 0;
      always @(posedge clk) begin
         #1;
         if (addr_s[g] !== last_addr) age = 0;
         else if (age < 100) age++;
         last_addr = addr_s[g];
      end
      assign data_s[g] = (age >= g + 1 && ce_s[g] === 1'b0 && oe_s[g] === 1'b0) ? sb(addr_s[g]) : 8'hee;
   end

   task automatic start(input int s, input logic [127:0] k, input bit push);
      logic [127:0] kk;
      @(negedge clk);
      init_s[s] = 1'b1;
      key_s[s]  = k;
      if (push) begin
         kk = k;
         sb_q.push_back(kk);
         for (int r = 1; r <= 10; r++) begin
            kk = next_key(kk, r);
            sb_q.push_back(kk);
         end
      end
      @(posedge clk);
      #1;
      init_s[s] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         vectors++;
         if ({ready_s[s], ce_s[s], oe_s[s], addr_s[s]} !== {3'b011, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs[%0d]: got ready/ce/oe/addr %b%b%b/%h want 011/00", s, ready_s[s], ce_s[s], oe_s[s], addr_s[s]);
         end
         for (int r = 0; r < 16; r++) begin
            round_s[s] = 4'(r);
            #2;
            vectors++;
            if (rk_s[s] !== '0) begin
               miscompares++;
               $display("FAIL reset_round_key[%0d] round %0d: got %h want 0", s, r, rk_s[s]);
            end
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fips_rw1();
      logic [7:0]   seen [4];
      logic [127:0] exp;
      int           lat;
      start(0, FIPS_KEY, 1'b1);
      lat = -1;
      for (int i = 0; i < 140 && lat < 0; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (ready_s[0] === 1'b1) lat = i;
         else if (i < 90) begin
            vectors++;
            if (addr_s[0] !== exp_addr(FIPS_KEY, 1, i)) begin
               miscompares++;
               $display("FAIL fips_rom_addr cycle %0d: got %h want %h", i, addr_s[0], exp_addr(FIPS_KEY, 1, i));
            end
            vectors++;
            if ({ce_s[0], oe_s[0]} !== 2'b00) begin
               miscompares++;
               $display("FAIL fips_strobes cycle %0d: got %b%b want 00", i, ce_s[0], oe_s[0]);
            end
         end
         if (i < 8 && i % 2 == 0) seen[i/2] = addr_s[0];
      end
      vectors++;
      if (lat != 90) begin miscompares++; $display("FAIL fips_ready_latency: got %0d want 90", lat); end
      vectors++;
      if ({seen[0], seen[1], seen[2], seen[3]} !== 32'hcf4f3c09) begin
         miscompares++;
         $display("FAIL fips_round1_addr_seq: got %h%h%h%h want cf4f3c09", seen[0], seen[1], seen[2], seen[3]);
      end
      vectors++;
      if ({ce_s[0], oe_s[0]} !== 2'b11) begin miscompares++; $display("FAIL fips_strobes_idle: got %b%b want 11", ce_s[0], oe_s[0]); end
      for (int r = 0; r <= 10; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (sb_q.size() == 0) begin miscompares++; $display("FAIL fips_scoreboard round %0d: got empty queue want entry", r); end
         else begin
            exp = sb_q.pop_front();
            if (rk_s[0] !== exp) begin miscompares++; $display("FAIL fips_round_key %0d: got %h want %h", r, rk_s[0], exp); end
         end
      end
      round_s[0] = 4'd1;  #2; vectors++;
      if (rk_s[0] !== FIPS_R1)  begin miscompares++; $display("FAIL fips_r1: got %h want %h", rk_s[0], FIPS_R1); end
      round_s[0] = 4'd10; #2; vectors++;
      if (rk_s[0] !== FIPS_R10) begin miscompares++; $display("FAIL fips_r10: got %h want %h", rk_s[0], FIPS_R10); end
      round_s[0] = 4'd0;  #2; vectors++;
      if (rk_s[0] !== FIPS_KEY) begin miscompares++; $display("FAIL fips_r0: got %h want %h", rk_s[0], FIPS_KEY); end
   endtask

   task automatic test_zero_rw2();
      logic [127:0] exp;
      int           lat;
      start(1, '0, 1'b1);
      lat = -1;
      for (int i = 0; i < 180 && lat < 0; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (ready_s[1] === 1'b1) lat = i;
         else if (i < 130) begin
            vectors++;
            if (addr_s[1] !== exp_addr('0, 2, i)) begin
               miscompares++;
               $display("FAIL zero_rom_addr cycle %0d: got %h want %h", i, addr_s[1], exp_addr('0, 2, i));
            end
            vectors++;
            if ({ce_s[1], oe_s[1]} !== 2'b00) begin
               miscompares++;
               $display("FAIL zero_strobes cycle %0d: got %b%b want 00", i, ce_s[1], oe_s[1]);
            end
         end
      end
      vectors++;
      if (lat != 130) begin miscompares++; $display("FAIL zero_ready_latency: got %0d want 130", lat); end
      for (int r = 0; r <= 10; r++) begin
         round_s[1] = 4'(r);
         #2;
         vectors++;
         if (sb_q.size() == 0) begin miscompares++; $display("FAIL zero_scoreboard round %0d: got empty queue want entry", r); end
         else begin
            exp = sb_q.pop_front();
            if (rk_s[1] !== exp) begin miscompares++; $display("FAIL zero_round_key %0d: got %h want %h", r, rk_s[1], exp); end
         end
      end
      round_s[1] = 4'd1;  #2; vectors++;
      if (rk_s[1] !== ZERO_R1)  begin miscompares++; $display("FAIL zero_r1: got %h want %h", rk_s[1], ZERO_R1); end
      round_s[1] = 4'd10; #2; vectors++;
      if (rk_s[1] !== ZERO_R10) begin miscompares++; $display("FAIL zero_r10: got %h want %h", rk_s[1], ZERO_R10); end
   endtask

   task automatic test_init_busy();
      logic [127:0] exp;
      int           lat;
      start(0, FIPS_KEY, 1'b1);
      lat = -1;
      for (int i = 1; i < 140 && lat < 0; i++) begin
         if (i == 40) begin
            @(negedge clk);
            init_s[0] = 1'b1;
            key_s[0]  = ALT_KEY;
         end
         @(posedge clk);
         #1;
         init_s[0] = 1'b0;
         if (ready_s[0] === 1'b1) lat = i;
         else if (i < 90) begin
            vectors++;
            if (addr_s[0] !== exp_addr(FIPS_KEY, 1, i)) begin
               miscompares++;
               $display("FAIL busy_rom_addr cycle %0d: got %h want %h", i, addr_s[0], exp_addr(FIPS_KEY, 1, i));
            end
         end
      end
      vectors++;
      if (lat != 90) begin miscompares++; $display("FAIL busy_ready_latency: got %0d want 90", lat); end
      for (int r = 0; r <= 10; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (sb_q.size() == 0) begin miscompares++; $display("FAIL busy_scoreboard round %0d: got empty queue want entry", r); end
         else begin
            exp = sb_q.pop_front();
            if (rk_s[0] !== exp) begin miscompares++; $display("FAIL busy_round_key %0d: got %h want %h", r, rk_s[0], exp); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp;
      int           lat;
      start(0, FIPS_KEY, 1'b0);
      for (int i = 1; i <= 50; i++) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({ready_s[0], ce_s[0], oe_s[0], addr_s[0]} !== {3'b011, 8'h00}) begin
         miscompares++;
         $display("FAIL midreset_outputs: got ready/ce/oe/addr %b%b%b/%h want 011/00", ready_s[0], ce_s[0], oe_s[0], addr_s[0]);
      end
      for (int r = 0; r <= 10; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (rk_s[0] !== '0) begin miscompares++; $display("FAIL midreset_round_key %0d: got %h want 0", r, rk_s[0]); end
      end
      @(negedge clk);
      reset_n = 1'b1;
      start(0, FIPS_KEY, 1'b1);
      lat = -1;
      for (int i = 1; i < 140 && lat < 0; i++) begin
         @(posedge clk);
         #1;
         if (ready_s[0] === 1'b1) lat = i;
      end
      vectors++;
      if (lat != 90) begin miscompares++; $display("FAIL midreset_ready_latency: got %0d want 90", lat); end
      for (int r = 0; r <= 10; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (sb_q.size() == 0) begin miscompares++; $display("FAIL midreset_scoreboard round %0d: got empty queue want entry", r); end
         else begin
            exp = sb_q.pop_front();
            if (rk_s[0] !== exp) begin miscompares++; $display("FAIL midreset_round_key_after %0d: got %h want %h", r, rk_s[0], exp); end
         end
      end
   endtask

   task automatic test_reinit();
      logic [127:0] exp;
      int           lat;
      for (int r = 11; r < 16; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (rk_s[0] !== '0) begin miscompares++; $display("FAIL out_of_range round %0d: got %h want 0", r, rk_s[0]); end
      end
      start(0, '0, 1'b1);
      vectors++;
      if (ready_s[0] !== 1'b0) begin miscompares++; $display("FAIL reinit_ready_drop: got %b want 0", ready_s[0]); end
      lat = -1;
      for (int i = 1; i < 140 && lat < 0; i++) begin
         @(posedge clk);
         #1;
         if (ready_s[0] === 1'b1) lat = i;
      end
      vectors++;
      if (lat != 90) begin miscompares++; $display("FAIL reinit_ready_latency: got %0d want 90", lat); end
      for (int r = 0; r <= 10; r++) begin
         round_s[0] = 4'(r);
         #2;
         vectors++;
         if (sb_q.size() == 0) begin miscompares++; $display("FAIL reinit_scoreboard round %0d: got empty queue want entry", r); end
         else begin
            exp = sb_q.pop_front();
            if (rk_s[0] !== exp) begin miscompares++; $display("FAIL reinit_round_key %0d: got %h want %h", r, rk_s[0], exp); end
         end
      end
      round_s[0] = 4'd1;  #2; vectors++;
      if (rk_s[0] !== ZERO_R1)  begin miscompares++; $display("FAIL reinit_r1: got %h want %h", rk_s[0], ZERO_R1); end
      round_s[0] = 4'd10; #2; vectors++;
      if (rk_s[0] !== ZERO_R10) begin miscompares++; $display("FAIL reinit_r10: got %h want %h", rk_s[0], ZERO_R10); end
   endtask

   initial begin
      reset_n    = 1'b0;
      init_s[0]  = 1'b0;
      init_s[1]  = 1'b0;
      key_s[0]   = '0;
      key_s[1]   = '0;
      round_s[0] = 4'd0;
      round_s[1] = 4'd0;
      test_reset();
      test_fips_rw1();
      test_zero_rw2();
      test_init_busy();
      test_reset_mid();
      test_reinit();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
